// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Register-hazard scoreboard for the decode stage. Each architectural
//   register except x0 has a saturating count of outstanding writes. The count
//   goes up by one when a writing instruction issues and down by one when its
//   writeback retires. A source register with a non-zero count raises its
//   bubble output. Issue stalls while the destination counter is saturated.
//
// Parameters
//   NREG   number of architectural registers (x0 is never tracked)
//   CNT_W  width of each pending-write counter (max outstanding = 2**CNT_W-1)
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   issue_valid    an instruction issues this cycle
//   issue_wen      the issued instruction writes issue_rd
//   issue_rd       destination register of the issued instruction
//   issue_ready    0 while issue_rd is saturated; decode must hold
//   retire_valid   writeback completes a register write this cycle
//   retire_rd      register written back
//   rs1, rs2       source registers of the instruction in decode
//   bubble1/2      rs1/rs2 has a pending write
//   pending_total  registered sum of all counters
//   underflow_err  sticky; set when a retire hits a zero counter
//
// Configuration
//   SCOREBOARD_BYPASS_EN  when defined, a retire that takes a counter from 1
//                         to 0 clears the matching bubble in the same cycle.

module reg_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_wen,
  input  logic [4:0]       issue_rd,
  output logic             issue_ready,
  input  logic             retire_valid,
  input  logic [4:0]       retire_rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             bubble1,
  output logic             bubble2,
  output logic [CNT_W+4:0] pending_total,
  output logic             underflow_err
);

  localparam int unsigned TW    = CNT_W + 5;
  localparam int unsigned IDX_W = $clog2(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]              total_q, total_d;
  logic                       underflow_q, underflow_d;

  logic inc, dec, same_rd;

  always_comb begin
    dec     = retire_valid && (retire_rd != '0);
    same_rd = dec && (retire_rd == issue_rd);

    // A retire to the same register in this cycle makes room, so a
    // saturated counter does not stall that issue.
    issue_ready = 1'b1;
    if ((issue_rd != '0) && (cnt_q[issue_rd] == CNT_MAX) && !same_rd)
      issue_ready = 1'b0;

    inc = issue_valid && issue_wen && issue_ready && (issue_rd != '0);

    underflow_d = underflow_q || (dec && (cnt_q[retire_rd] == '0));

    cnt_d = cnt_q;
    // Same-register inc and dec cancel; otherwise apply each on its own.
    // A dec on a zero counter leaves it at zero.
    if (inc && !same_rd)
      cnt_d[issue_rd] = cnt_q[issue_rd] + CNT_ONE;
    if (dec && !(inc && same_rd) && (cnt_q[retire_rd] != '0))
      cnt_d[retire_rd] = cnt_q[retire_rd] - CNT_ONE;
    cnt_d[0] = '0;

    total_d = '0;
    for (int unsigned r = 0; r < NREG; r++)
      total_d = total_d + TW'(cnt_d[r[IDX_W-1:0]]);
  end

  always_comb begin
    bubble1 = (rs1 != '0) && (cnt_q[rs1] != '0);
    bubble2 = (rs2 != '0) && (cnt_q[rs2] != '0);
`ifdef SCOREBOARD_BYPASS_EN
    // Last outstanding write to this register is retiring now.
    if (dec && (retire_rd == rs1) && (cnt_q[rs1] == CNT_ONE))
      bubble1 = 1'b0;
    if (dec && (retire_rd == rs2) && (cnt_q[rs2] == CNT_ONE))
      bubble2 = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      total_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      underflow_q <= underflow_d;
    end
  end

  assign pending_total = total_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  localparam int NREG  = 32;
  localparam int CNT_W = 2;
  localparam int TW    = CNT_W + 5;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid, issue_wen, retire_valid;
  logic [4:0]    issue_rd, retire_rd, rs1, rs2;
  logic          issue_ready, bubble1, bubble2, underflow_err;
  logic [TW-1:0] pending_total;

  int checks = 0;
  int errors = 0;

  // reference state: outstanding writes per register, sticky error
  int mcnt[NREG];
  bit merr;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .rs1(rs1), .rs2(rs2), .bubble1(bubble1), .bubble2(bubble2),
    .pending_total(pending_total), .underflow_err(underflow_err)
  );

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic void model_reset();
    foreach (mcnt[r]) mcnt[r] = 0;
    merr = 1'b0;
  endfunction

  function automatic bit m_ready();
    if (issue_rd == 0) return 1'b1;
    if (mcnt[issue_rd] < MAXC) return 1'b1;
    if (retire_valid && retire_rd == issue_rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_bubble(input logic [4:0] rs);
    if (rs == 0 || mcnt[rs] == 0) return 1'b0;
    if (BYP && retire_valid && retire_rd == rs && mcnt[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_total();
    int s = 0;
    foreach (mcnt[r]) s += mcnt[r];
    return s;
  endfunction

  // apply the cycle's inputs to the reference counts (pre-edge view)
  function automatic void model_commit();
    int delta[NREG];
    foreach (delta[r]) delta[r] = 0;
    if (issue_valid && issue_wen && issue_rd != 0 && m_ready()) delta[issue_rd] += 1;
    if (retire_valid && retire_rd != 0) begin
      if (mcnt[retire_rd] == 0) merr = 1'b1;
      delta[retire_rd] -= 1;
    end
    foreach (mcnt[r]) begin
      mcnt[r] += delta[r];
      if (mcnt[r] < 0) mcnt[r] = 0;
    end
  endfunction

  task automatic drive(input bit iv, input bit iw, input int ird,
                       input bit rv, input int rrd, input int r1, input int r2);
    issue_valid  = iv;
    issue_wen    = iw;
    issue_rd     = 5'(ird);
    retire_valid = rv;
    retire_rd    = 5'(rrd);
    rs1          = 5'(r1);
    rs2          = 5'(r2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 1, 7, 0, 0, 5, 3);
    @(posedge clk);
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", issue_ready); end
    checks++; if ({bubble1, bubble2} !== 2'b00) begin errors++; $display("FAIL rst_bubbles got %b exp 00", {bubble1, bubble2}); end
    checks++; if (pending_total !== '0) begin errors++; $display("FAIL rst_total got %0d exp 0", pending_total); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", underflow_err); end
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_issue_retire();
    drive(1, 1, 5, 0, 0, 5, 0);
    @(negedge clk);
    checks++; if (bubble1 !== 1'b0) begin errors++; $display("FAIL ir_bubble_issue_cycle got %b exp 0", bubble1); end
    tick();
    checks++; if (pending_total !== TW'(1)) begin errors++; $display("FAIL ir_total got %0d exp 1", pending_total); end
    drive(0, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    checks++; if (bubble1 !== 1'b1) begin errors++; $display("FAIL ir_bubble_busy got %b exp 1", bubble1); end
    tick();
    drive(0, 0, 0, 1, 5, 5, 5);
    @(negedge clk);
    checks++; if ({bubble1, bubble2} !== {2{~BYP}}) begin errors++; $display("FAIL ir_bubble_retire_cycle got %b exp %b", {bubble1, bubble2}, {2{~BYP}}); end
    tick();
    drive(0, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    checks++; if (bubble1 !== 1'b0) begin errors++; $display("FAIL ir_bubble_after_retire got %b exp 0", bubble1); end
    checks++; if (pending_total !== '0) begin errors++; $display("FAIL ir_total_after got %0d exp 0", pending_total); end
    tick();
  endtask

  task automatic test_zero_reg();
    drive(1, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    checks++; if ({issue_ready, bubble1, bubble2} !== 3'b100) begin errors++; $display("FAIL zero_outputs got %b exp 100", {issue_ready, bubble1, bubble2}); end
    tick();
    drive(1, 0, 6, 0, 0, 6, 0);
    tick();
    checks++; if ({pending_total, underflow_err} !== {TW'(0), 1'b0}) begin errors++; $display("FAIL zero_total_err got %0d/%b exp 0/0", pending_total, underflow_err); end
    drive(0, 0, 0, 0, 0, 6, 0);
    @(negedge clk);
    checks++; if (bubble1 !== 1'b0) begin errors++; $display("FAIL nowen_bubble got %b exp 0", bubble1); end
    tick();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 7, 0, 0, 7, 0);
      tick();
    end
    drive(1, 1, 7, 0, 0, 7, 0);
    @(negedge clk);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_ready got %b exp 0", issue_ready); end
    tick();
    checks++; if (pending_total !== TW'(3)) begin errors++; $display("FAIL sat_total_stalled got %0d exp 3", pending_total); end
    drive(1, 1, 7, 1, 7, 7, 0);
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_ready_same_retire got %b exp 1", issue_ready); end
    tick();
    checks++; if (pending_total !== TW'(3)) begin errors++; $display("FAIL sat_total_net0 got %0d exp 3", pending_total); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 7, 0, 0);
      tick();
    end
    checks++; if ({pending_total, underflow_err} !== {TW'(0), 1'b0}) begin errors++; $display("FAIL sat_drain got %0d/%b exp 0/0", pending_total, underflow_err); end
  endtask

  task automatic test_cross();
    drive(1, 1, 4, 0, 0, 0, 0);
    tick();
    drive(1, 1, 3, 1, 4, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 3, 4);
    @(negedge clk);
    checks++; if ({bubble1, bubble2} !== 2'b10) begin errors++; $display("FAIL cross_bubbles got %b exp 10", {bubble1, bubble2}); end
    checks++; if (pending_total !== TW'(1)) begin errors++; $display("FAIL cross_total got %0d exp 1", pending_total); end
    tick();
    drive(0, 0, 0, 1, 3, 0, 0);
    tick();
  endtask

  task automatic test_underflow();
    drive(0, 0, 0, 1, 9, 9, 0);
    @(negedge clk);
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL uf_before got %b exp 0", underflow_err); end
    tick();
    checks++; if ({underflow_err, pending_total} !== {1'b1, TW'(0)}) begin errors++; $display("FAIL uf_set got %b/%0d exp 1/0", underflow_err, pending_total); end
    drive(0, 0, 0, 0, 0, 9, 0);
    @(negedge clk);
    checks++; if (bubble1 !== 1'b0) begin errors++; $display("FAIL uf_no_wrap got %b exp 0", bubble1); end
    tick();
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", underflow_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
      @(negedge clk);
      checks++;
      if ({issue_ready, bubble1, bubble2} !== {m_ready(), m_bubble(rs1), m_bubble(rs2)}) begin
        errors++;
        $display("FAIL rnd_comb cyc %0d got %b exp %b", i, {issue_ready, bubble1, bubble2},
                 {m_ready(), m_bubble(rs1), m_bubble(rs2)});
      end
      tick();
      checks++;
      if ({pending_total, underflow_err} !== {TW'(m_total()), merr}) begin
        errors++;
        $display("FAIL rnd_state cyc %0d got %0d/%b exp %0d/%b", i, pending_total, underflow_err, m_total(), merr);
      end
    end
  endtask

  task automatic test_midreset();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    model_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(1, 1, 5, 0, 0, 5, 0);
    tick();
    tick();
    checks++; if (pending_total !== TW'(2)) begin errors++; $display("FAIL mr_setup got %0d exp 2", pending_total); end
    drive(0, 0, 0, 1, 9, 5, 0);
    tick();
    drive(0, 0, 0, 0, 0, 5, 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++; if ({bubble1, issue_ready, pending_total, underflow_err} !== {1'b0, 1'b1, TW'(0), 1'b0}) begin
      errors++;
      $display("FAIL mr_async got b1=%b rdy=%b tot=%0d err=%b exp 0/1/0/0", bubble1, issue_ready, pending_total, underflow_err);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({bubble1, pending_total, underflow_err} !== {1'b0, TW'(0), 1'b0}) begin
      errors++;
      $display("FAIL mr_after got b1=%b tot=%0d err=%b exp 0/0/0", bubble1, pending_total, underflow_err);
    end
    tick();
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_issue_retire();
    test_zero_reg();
    test_saturate();
    test_cross();
    test_underflow();
    test_random();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
